// File: rtl/decoder_scan.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with an auto-scan mode that walks the
// one-hot output across every index, holding each for a latched dwell time.
module decoder_scan #(
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned DWELL_W = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  mode_i,
  input  logic [SEL_W-1:0]      sel_i,
  input  logic                  start_i,
  input  logic [DWELL_W-1:0]    dwell_i,
  output logic [2**SEL_W-1:0]   out_o,
  output logic [SEL_W-1:0]      cur_idx_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned OUT_W = 2 ** SEL_W;
  localparam logic [SEL_W-1:0] LastIdx = SEL_W'(OUT_W - 1);

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  state_e               state_q, state_d;
  logic [OUT_W-1:0]     out_q, out_d;
  logic [SEL_W-1:0]     idx_q, idx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;

  logic start_ok;
  logic last_beat;

  assign start_ok  = en_i && mode_i && start_i;
  assign last_beat = (cnt_q == '0) && (idx_q == LastIdx);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start_ok) state_d = StScan;
      StScan: if (!en_i || last_beat) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    out_d   = out_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          dwell_d = dwell_i;
          cnt_d   = dwell_i;
          idx_d   = '0;
          out_d   = OUT_W'(1);
          busy_d  = 1'b1;
        end else if (en_i && !mode_i) begin
          out_d  = OUT_W'(1) << sel_i;
          idx_d  = sel_i;
          busy_d = 1'b0;
        end else begin
          out_d  = '0;
          idx_d  = '0;
          busy_d = 1'b0;
        end
      end
      StScan: begin
        if (!en_i) begin
          out_d  = '0;
          idx_d  = '0;
          busy_d = 1'b0;
        end else if (last_beat) begin
          out_d  = '0;
          idx_d  = '0;
          busy_d = 1'b0;
          done_d = 1'b1;
        end else if (cnt_q == '0) begin
          // Single shift keeps the output strictly one-hot across the index step.
          out_d = out_q << 1;
          idx_d = idx_q + SEL_W'(1);
          cnt_d = dwell_q;
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end
      default: begin
        out_d  = '0;
        idx_d  = '0;
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dwell_q <= '0;
      cnt_q   <= '0;
    end else begin
      out_q   <= out_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_o     = out_q;
  assign cur_idx_o = idx_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Directed bench for decoder_scan: a SEL_W=2 and a SEL_W=3 instance share stimulus.
module tb_decoder_scan;

  logic       clk;
  logic       rst;
  logic       en;
  logic       mode;
  logic [2:0] sel;
  logic       start;
  logic [3:0] dwell;

  logic [3:0] o2;
  logic [1:0] i2;
  logic       b2, d2;
  logic [7:0] o3;
  logic [2:0] i3;
  logic       b3, d3;

  int checks = 0;
  int errors = 0;

  decoder_scan #(.SEL_W(2), .DWELL_W(4)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .sel_i(sel[1:0]),
    .start_i(start), .dwell_i(dwell), .out_o(o2), .cur_idx_o(i2), .busy_o(b2), .done_o(d2)
  );

  decoder_scan #(.SEL_W(3), .DWELL_W(4)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .sel_i(sel),
    .start_i(start), .dwell_i(dwell), .out_o(o3), .cur_idx_o(i3), .busy_o(b3), .done_o(d3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [3:0] eo, input logic [1:0] ei,
                      input logic eb, input logic ed);
    chk({tag, ".out"},  32'(o2), 32'(eo));
    chk({tag, ".idx"},  32'(i2), 32'(ei));
    chk({tag, ".busy"}, 32'(b2), 32'(eb));
    chk({tag, ".done"}, 32'(d2), 32'(ed));
  endtask

  initial begin
    rst   = 1'b1;
    en    = 1'($urandom);
    mode  = 1'($urandom);
    sel   = 3'($urandom);
    start = 1'($urandom);
    dwell = 4'($urandom);
    tick();
    tick();
    chk2("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    chk("reset.out3", 32'(o3), 32'h0);

    // Direct sweep
    rst = 1'b0; en = 1'b1; mode = 1'b0; start = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel = 3'(s);
      tick();
      chk2("direct", 4'(1 << s), 2'(s), 1'b0, 1'b0);
    end
    en = 1'b0;
    tick();
    chk2("direct_en0", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Start with mode=0 is plain decode
    en = 1'b1; mode = 1'b0; sel = 3'd2; start = 1'b1;
    tick();
    start = 1'b0;
    chk2("start_mode0", 4'b0100, 2'd2, 1'b0, 1'b0);

    // Scan, dwell=2, with mid-scan disturbances
    mode = 1'b1; start = 1'b1; dwell = 4'd2;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      chk2("scan_d2", 4'(1 << ((c - 1) / 3)), 2'((c - 1) / 3), 1'b1, 1'b0);
      if (c == 4) begin
        dwell = 4'd7; sel = 3'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    chk2("scan_d2_done", 4'b0000, 2'd0, 1'b0, 1'b1);
    tick();
    chk2("scan_d2_after", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Abort by en while index 2 is asserted
    start = 1'b1; dwell = 4'd3;
    tick();
    start = 1'b0;
    for (int c = 1; c < 9; c++) tick();
    chk2("abort_en_pre", 4'b0100, 2'd2, 1'b1, 1'b0);
    en = 1'b0;
    tick();
    chk2("abort_en", 4'b0000, 2'd0, 1'b0, 1'b0);
    en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("abort_en_nodone", 32'(d2), 32'h0);
    end

    // Abort by reset while index 2 is asserted
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 9; c++) tick();
    chk2("abort_rst_pre", 4'b0100, 2'd2, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    chk2("abort_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("abort_rst_nodone", 32'(d2), 32'h0);
    end

    // SEL_W=3, dwell=0, back-to-back scans
    dwell = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk("w3.out",  32'(o3), 32'(1 << (c - 1)));
      chk("w3.idx",  32'(i3), 32'(c - 1));
      chk("w3.busy", 32'(b3), 32'h1);
      if (c == 5) chk("w2_done_d0", 32'(d2), 32'h1);
      tick();
    end
    chk("w3_done.out",  32'(o3), 32'h0);
    chk("w3_done.busy", 32'(b3), 32'h0);
    chk("w3_done.done", 32'(d3), 32'h1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("w3_b2b.out",  32'(o3), 32'h01);
    chk("w3_b2b.busy", 32'(b3), 32'h1);
    chk("w3_b2b.done", 32'(d3), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
